// File: rtl/alt_trigin_timer_if.sv
// rtl/alt_trigin_timer_if.sv - register, timetag and trigger signals of the alternate trigger timer
interface alt_trigin_timer_if;
    // ctrl register: software enable value and its one-cycle write strobe
    logic        ctrl_enable_i;
    logic        ctrl_wr_i;
    logic        ctrl_enable_o;
    // programmed trigger time and its readback shadow
    logic [63:0] tgt_seconds_i;
    logic [31:0] tgt_cycles_i;
    logic [63:0] seconds_o;
    logic [31:0] cycles_o;
    // White Rabbit timetag
    logic [63:0] tm_seconds_i;
    logic [31:0] tm_cycles_i;
    logic        tm_valid_i;
    // trigger output and status
    logic        trig_p_o;
    logic        late_o;
    logic [31:0] trig_count_o;

    // register bank / timing core side
    modport master (
        output ctrl_enable_i, ctrl_wr_i, tgt_seconds_i, tgt_cycles_i,
        output tm_seconds_i, tm_cycles_i, tm_valid_i,
        input  ctrl_enable_o, seconds_o, cycles_o, trig_p_o, late_o, trig_count_o
    );

    // timer side
    modport slave (
        input  ctrl_enable_i, ctrl_wr_i, tgt_seconds_i, tgt_cycles_i,
        input  tm_seconds_i, tm_cycles_i, tm_valid_i,
        output ctrl_enable_o, seconds_o, cycles_o, trig_p_o, late_o, trig_count_o
    );
endinterface

// File: rtl/alt_trigin_timer.sv
// rtl/alt_trigin_timer.sv - time-based trigger generator for the FMC ADC alternate trigger input
module alt_trigin_timer #(
    parameter int unsigned g_CYCLES_MAX = 125000000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alt_trigin_timer_if.slave  bus
);

    // armed flag, target shadow and status
    logic        armed_q,  armed_d;
    logic [63:0] sec_q,    sec_d;
    logic [31:0] cyc_q,    cyc_d;
    logic        late_q,   late_d;
    logic        trig_q,   trig_d;
    logic [31:0] count_q,  count_d;

    // stage 1 of the compare pipeline
    logic        v1_q,  v1_d;
    logic        sgt_q, sgt_d;
    logic        seq_q, seq_d;
    logic        cge_q, cge_d;
    logic        ceq_q, ceq_d;

    // stage 2 result and the fire decision
    logic        hit;
    logic        fire;

    // Stage 1: compare the timetag against the shadow only. A ctrl write
    // invalidates the slot so a re-arm is never judged against the old target.
    always_comb begin
        v1_d  = armed_q & bus.tm_valid_i & ~bus.ctrl_wr_i;
        sgt_d = bus.tm_seconds_i >  sec_q;
        seq_d = bus.tm_seconds_i == sec_q;
        cge_d = bus.tm_cycles_i  >= cyc_q;
        ceq_d = bus.tm_cycles_i  == cyc_q;
    end

    // Stage 2 plus arm/disarm/fire control; a ctrl write always beats a hit,
    // and gating on the live armed flag drops stale hits after a disarm.
    always_comb begin
        armed_d = armed_q;
        sec_d   = sec_q;
        cyc_d   = cyc_q;
        late_d  = late_q;
        count_d = count_q;
        trig_d  = 1'b0;

        hit  = v1_q & (sgt_q | (seq_q & cge_q));
        fire = hit & armed_q & ~bus.ctrl_wr_i;

        if (bus.ctrl_wr_i) begin
            armed_d = bus.ctrl_enable_i;
            if (bus.ctrl_enable_i) begin
                sec_d  = bus.tgt_seconds_i;
                cyc_d  = bus.tgt_cycles_i;
                late_d = 1'b0;
            end
        end else if (fire) begin
            trig_d  = 1'b1;
            armed_d = 1'b0;
            count_d = count_q + 32'd1;
            late_d  = ~(seq_q & ceq_q);
        end
    end

    // State registers with synchronous reset; reset also flushes the pipeline
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            armed_q <= 1'b0;
            sec_q   <= '0;
            cyc_q   <= '0;
            late_q  <= 1'b0;
            trig_q  <= 1'b0;
            count_q <= '0;
            v1_q    <= 1'b0;
            sgt_q   <= 1'b0;
            seq_q   <= 1'b0;
            cge_q   <= 1'b0;
            ceq_q   <= 1'b0;
        end else begin
            armed_q <= armed_d;
            sec_q   <= sec_d;
            cyc_q   <= cyc_d;
            late_q  <= late_d;
            trig_q  <= trig_d;
            count_q <= count_d;
            v1_q    <= v1_d;
            sgt_q   <= sgt_d;
            seq_q   <= seq_d;
            cge_q   <= cge_d;
            ceq_q   <= ceq_d;
        end
    end

    assign bus.ctrl_enable_o = armed_q;
    assign bus.seconds_o     = sec_q;
    assign bus.cycles_o      = cyc_q;
    assign bus.trig_p_o      = trig_q;
    assign bus.late_o        = late_q;
    assign bus.trig_count_o  = count_q;

    // A locked timetag never reports a cycles value outside the second
    a_cycles_range: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.tm_valid_i |-> (bus.tm_cycles_i < g_CYCLES_MAX));

endmodule

// File: tb/tb_alt_trigin_timer.sv
// tb/tb_alt_trigin_timer.sv - directed self-checking bench for alt_trigin_timer
module tb_alt_trigin_timer;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    alt_trigin_timer_if bus_if ();

    alt_trigin_timer #(.g_CYCLES_MAX(125000000)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_time(input logic [63:0] s, input logic [31:0] c);
        bus_if.tm_seconds_i = s;
        bus_if.tm_cycles_i  = c;
    endtask

    // drive a ctrl write for one cycle; returns in the cycle after the write
    task automatic ctrl_write(input logic en, input logic [63:0] s, input logic [31:0] c);
        bus_if.ctrl_enable_i = en;
        bus_if.tgt_seconds_i = s;
        bus_if.tgt_cycles_i  = c;
        bus_if.ctrl_wr_i     = 1'b1;
        step();
        bus_if.ctrl_wr_i     = 1'b0;
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_en"},    64'(bus_if.ctrl_enable_o), 64'd0);
        chk({tag, "_trig"},  64'(bus_if.trig_p_o),      64'd0);
        chk({tag, "_late"},  64'(bus_if.late_o),        64'd0);
        chk({tag, "_count"}, 64'(bus_if.trig_count_o),  64'd0);
        chk({tag, "_sec"},   bus_if.seconds_o,          64'd0);
        chk({tag, "_cyc"},   64'(bus_if.cycles_o),      64'd0);
    endtask

    initial begin
        bus_if.ctrl_enable_i = 1'b0;
        bus_if.ctrl_wr_i     = 1'b0;
        bus_if.tgt_seconds_i = '0;
        bus_if.tgt_cycles_i  = '0;
        bus_if.tm_valid_i    = 1'b1;
        set_time(64'd10, 32'd990);

        // reset state
        step(); step();
        rst_i = 1'b0;
        step();
        chk_outputs_reset("rst");

        // exact match at (10, 1000); target inputs changed after arm must be ignored
        ctrl_write(1'b1, 64'd10, 32'd1000);
        bus_if.tgt_seconds_i = 64'd0;
        bus_if.tgt_cycles_i  = 32'd0;
        chk("exact_arm_en", 64'(bus_if.ctrl_enable_o), 64'd1);
        chk("exact_arm_sec", bus_if.seconds_o, 64'd10);
        chk("exact_arm_cyc", 64'(bus_if.cycles_o), 64'd1000);
        set_time(64'd10, 32'd998);  step(); chk("exact_998",  64'(bus_if.trig_p_o), 64'd0);
        set_time(64'd10, 32'd999);  step(); chk("exact_999",  64'(bus_if.trig_p_o), 64'd0);
        set_time(64'd10, 32'd1000); step(); chk("exact_m1",   64'(bus_if.trig_p_o), 64'd0);
        set_time(64'd10, 32'd1001); step();
        chk("exact_m2_trig",  64'(bus_if.trig_p_o),      64'd1);
        chk("exact_m2_late",  64'(bus_if.late_o),        64'd0);
        chk("exact_m2_count", 64'(bus_if.trig_count_o),  64'd1);
        chk("exact_m2_en",    64'(bus_if.ctrl_enable_o), 64'd0);
        step(); chk("exact_m3_trig", 64'(bus_if.trig_p_o), 64'd0);

        // past target: fire in n+3, late, single pulse while time stalls
        set_time(64'd20, 32'd5);
        ctrl_write(1'b1, 64'd19, 32'd124999999);
        chk("past_n1", 64'(bus_if.trig_p_o), 64'd0);
        step(); chk("past_n2", 64'(bus_if.trig_p_o), 64'd0);
        step();
        chk("past_n3_trig",  64'(bus_if.trig_p_o),     64'd1);
        chk("past_n3_late",  64'(bus_if.late_o),       64'd1);
        chk("past_n3_count", 64'(bus_if.trig_count_o), 64'd2);
        for (int i = 0; i < 3; i++) begin
            step(); chk("past_single", 64'(bus_if.trig_p_o), 64'd0);
        end

        // seconds boundary: fire on (5, 124999999) only, not again on (6, 0)
        set_time(64'd5, 32'd124999998);
        ctrl_write(1'b1, 64'd5, 32'd124999999);
        chk("sb_arm_late", 64'(bus_if.late_o), 64'd0);
        step(); step(); chk("sb_before", 64'(bus_if.trig_p_o), 64'd0);
        set_time(64'd5, 32'd124999999); step(); chk("sb_m1", 64'(bus_if.trig_p_o), 64'd0);
        set_time(64'd6, 32'd0); step();
        chk("sb_m2_trig",  64'(bus_if.trig_p_o),     64'd1);
        chk("sb_m2_late",  64'(bus_if.late_o),       64'd0);
        chk("sb_m2_count", 64'(bus_if.trig_count_o), 64'd3);
        step(); chk("sb_no_second_a", 64'(bus_if.trig_p_o), 64'd0);
        step(); chk("sb_no_second_b", 64'(bus_if.trig_p_o), 64'd0);

        // disarm race: write of 0 on the hit cycle suppresses the fire
        set_time(64'd30, 32'd50);
        ctrl_write(1'b1, 64'd30, 32'd100);
        step(); step();
        set_time(64'd30, 32'd100); step();
        chk("dis_hit_cycle", 64'(bus_if.trig_p_o), 64'd0);
        ctrl_write(1'b0, 64'd0, 32'd0);
        chk("dis_trig",  64'(bus_if.trig_p_o),      64'd0);
        chk("dis_en",    64'(bus_if.ctrl_enable_o), 64'd0);
        chk("dis_count", 64'(bus_if.trig_count_o),  64'd3);
        step(); chk("dis_stale", 64'(bus_if.trig_p_o), 64'd0);

        // re-arm race: write of 1 on the hit cycle evaluates the new target afresh
        set_time(64'd30, 32'd50);
        ctrl_write(1'b1, 64'd30, 32'd200);
        step(); step();
        set_time(64'd30, 32'd200); step();
        ctrl_write(1'b1, 64'd40, 32'd0);
        chk("rearm_trig", 64'(bus_if.trig_p_o),      64'd0);
        chk("rearm_en",   64'(bus_if.ctrl_enable_o), 64'd1);
        chk("rearm_sec",  bus_if.seconds_o,          64'd40);
        step(); chk("rearm_old_a", 64'(bus_if.trig_p_o), 64'd0);
        step(); chk("rearm_old_b", 64'(bus_if.trig_p_o), 64'd0);
        chk("rearm_count", 64'(bus_if.trig_count_o), 64'd3);
        ctrl_write(1'b0, 64'd0, 32'd0);

        // tm_valid gating: stays armed while invalid, fires 2 cycles after valid rises
        bus_if.tm_valid_i = 1'b0;
        set_time(64'd50, 32'd0);
        ctrl_write(1'b1, 64'd50, 32'd10);
        set_time(64'd51, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(); chk("val_low_trig", 64'(bus_if.trig_p_o), 64'd0);
        end
        chk("val_low_en", 64'(bus_if.ctrl_enable_o), 64'd1);
        bus_if.tm_valid_i = 1'b1;
        step(); chk("val_t1", 64'(bus_if.trig_p_o), 64'd0);
        step();
        chk("val_t2_trig",  64'(bus_if.trig_p_o),     64'd1);
        chk("val_t2_late",  64'(bus_if.late_o),       64'd1);
        chk("val_t2_count", 64'(bus_if.trig_count_o), 64'd4);

        // reset while armed
        set_time(64'd60, 32'd0);
        ctrl_write(1'b1, 64'd70, 32'd0);
        step(); chk("rmid_armed", 64'(bus_if.ctrl_enable_o), 64'd1);
        rst_i = 1'b1;
        step();
        chk_outputs_reset("rmid");
        rst_i = 1'b0;
        step(); chk("rmid_after_a", 64'(bus_if.trig_p_o), 64'd0);
        step(); chk("rmid_after_b", 64'(bus_if.ctrl_enable_o), 64'd0);

        // counter wrap from a preset of 0xFFFFFFFF
        force dut.count_q = 32'hFFFF_FFFF;
        step();
        release dut.count_q;
        step(); chk("wrap_preset", 64'(bus_if.trig_count_o), 64'hFFFF_FFFF);
        set_time(64'd80, 32'd0);
        ctrl_write(1'b1, 64'd79, 32'd0);
        step(); step();
        chk("wrap_trig",  64'(bus_if.trig_p_o),     64'd1);
        chk("wrap_count", 64'(bus_if.trig_count_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
